// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : muldiv_pkg
// Purpose: Shared types for the HI/LO multiply-divide unit. This file holds
//          the operation encoding, the FSM state encoding and a
//          signedness helper.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_DIV   = 4'd2,
      OP_DIVU  = 4'd3,
      OP_MADD  = 4'd4,
      OP_MADDU = 4'd5,
      OP_MSUB  = 4'd6,
      OP_MSUBU = 4'd7,
      OP_MTHI  = 4'd8,
      OP_MTLO  = 4'd9
   } muldiv_op_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } muldiv_state_t;

   function automatic logic is_signed(input muldiv_op_t op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage
`default_nettype wire

// File: rtl/restoring_div_core.sv
`default_nettype none
// ============================================================================
// Module : restoring_div_core
// Purpose: Unsigned restoring divider datapath. It produces one quotient bit
//          per step. After WIDTH steps the quotient and remainder are final.
// Ports  : clk_i, rst_ni      clock / async active-low reset
//          load_i             capture dividend/divisor and clear remainder
//          step_i             perform one shift-subtract iteration
//          dividend_i         unsigned dividend
//          divisor_i          unsigned divisor (non-zero)
//          quot_o, rem_o      quotient / remainder
// Rev    : 1.0  initial release
// ============================================================================
module restoring_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] dvsr_q;
   logic [WIDTH:0]   shifted_d;
   logic [WIDTH:0]   diff_d;

   // The dividend shifts out of the quotient register MSB-first while the
   // quotient bits shift in at the bottom.
   assign shifted_d = {rem_q, quot_q[WIDTH-1]};
   assign diff_d    = shifted_d - {1'b0, dvsr_q};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_q  <= '0;
         quot_q <= '0;
         dvsr_q <= '0;
      end else if (load_i) begin
         rem_q  <= '0;
         quot_q <= dividend_i;
         dvsr_q <= divisor_i;
      end else if (step_i) begin
         // The partial remainder always stays below the divisor. Both
         // branches therefore fit back into WIDTH bits.
         if (!diff_d[WIDTH]) begin
            rem_q  <= diff_d[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q  <= shifted_d[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign quot_o = quot_q;
   assign rem_o  = rem_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Purpose: Iterative multiply/divide engine that owns the HI/LO pair. It
//          handles MULT(U), DIV(U), MADD(U), MSUB(U), MTHI and MTLO.
// Ports  : clk_i, rst_ni              clock / async active-low reset
//          start_i, op_i              issue request and operation
//          a_i, b_i                   rs / rt operands
//          flush_i                    abort current operation
//          busy_o, done_o, div_zero_o status (registered)
//          hi_o, lo_o                 architectural HI/LO
// Rev    : 1.0  initial release
// ============================================================================
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  muldiv_op_t       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH);

   muldiv_state_t      state_q;
   muldiv_op_t         op_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q, done_q, div_zero_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               sign_q;       // product / quotient sign
   logic               rem_sign_q;   // remainder follows the dividend
   logic [2*WIDTH-1:0] acc_q, mcand_q;
   logic [WIDTH-1:0]   mplier_q;

   logic               a_neg_d, b_neg_d;
   logic [WIDTH-1:0]   a_mag_d, b_mag_d;
   logic               accept_d, is_div_op_d, div_load_d;
   logic [2*WIDTH-1:0] acc_step_d, prod_d, hilo_fix_d;
   logic [WIDTH-1:0]   div_quot, div_rem, quot_fix_d, rem_fix_d;

   // Operand magnitudes. For a signed MIN operand the negation gives MIN
   // back, which is the correct unsigned magnitude 2^(W-1).
   assign a_neg_d = is_signed(op_i) & a_i[WIDTH-1];
   assign b_neg_d = is_signed(op_i) & b_i[WIDTH-1];
   assign a_mag_d = a_neg_d ? -a_i : a_i;
   assign b_mag_d = b_neg_d ? -b_i : b_i;

   // DONE accepts a new start exactly like IDLE. This lets issues run back-to-back with no gap.
   assign accept_d    = start_i && !flush_i && (state_q == S_IDLE || state_q == S_DONE);
   assign is_div_op_d = (op_i == OP_DIV) || (op_i == OP_DIVU);
   assign div_load_d  = accept_d && is_div_op_d && (b_i != '0);

   assign acc_step_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
   assign prod_d     = sign_q ? -acc_q : acc_q;
   assign quot_fix_d = sign_q ? -div_quot : div_quot;
   assign rem_fix_d  = rem_sign_q ? -div_rem : div_rem;

   always_comb begin
      hilo_fix_d = prod_d;
      case (op_q)
         OP_MADD, OP_MADDU: hilo_fix_d = {hi_q, lo_q} + prod_d;
         OP_MSUB, OP_MSUBU: hilo_fix_d = {hi_q, lo_q} - prod_d;
         default:           hilo_fix_d = prod_d;
      endcase
   end

   restoring_div_core #(.WIDTH(WIDTH)) u_div (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (div_load_d),
      .step_i     (state_q == S_DIV),
      .dividend_i (a_mag_d),
      .divisor_i  (b_mag_d),
      .quot_o     (div_quot),
      .rem_o      (div_rem)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         op_q       <= OP_MULT;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         sign_q     <= 1'b0;
         rem_sign_q <= 1'b0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
      end else if (flush_i) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               state_q    <= S_IDLE;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
               div_zero_q <= 1'b0;
               if (start_i) begin
                  op_q       <= op_i;
                  cnt_q      <= '0;
                  sign_q     <= a_neg_d ^ b_neg_d;
                  rem_sign_q <= a_neg_d;
                  case (op_i)
                     OP_MTHI: begin
                        hi_q    <= a_i;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                     OP_MTLO: begin
                        lo_q    <= a_i;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                     OP_DIV, OP_DIVU: begin
                        busy_q <= 1'b1;
                        if (b_i == '0) begin
                           done_q     <= 1'b1;
                           div_zero_q <= 1'b1;
                           state_q    <= S_DONE;
                        end else begin
                           state_q <= S_DIV;
                        end
                     end
                     OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                        busy_q   <= 1'b1;
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag_d};
                        mplier_q <= b_mag_d;
                        state_q  <= S_MUL;
                     end
                     default: state_q <= S_IDLE;
                  endcase
               end
            end
            S_MUL: begin
               acc_q    <= acc_step_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
            end
            S_DIV: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
            end
            S_FIX: begin
               if (op_q == OP_DIV || op_q == OP_DIVU) begin
                  lo_q <= quot_fix_d;
                  hi_q <= rem_fix_d;
               end else begin
                  {hi_q, lo_q} <= hilo_fix_d;
               end
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign div_zero_o = div_zero_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_unit
// Purpose: Directed self-checking bench for muldiv_unit at WIDTH=32.
// Rev    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   muldiv_op_t  op_i;
   logic [31:0] a_i, b_i;
   logic        flush_i;
   logic        busy_o, done_o, div_zero_o;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .op_i       (op_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .flush_i    (flush_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .div_zero_o (div_zero_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called 1 ns after a rising edge; returns 1 ns after the accepting edge.
   task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   // Counts edges from the accepting edge (counted as 1) until done is seen.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done_o && cyc < 100) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      if (!done_o) check("done_timeout", {63'd0, done_o}, 64'd1);
   endtask

   task automatic step();
      @(posedge clk_i); #1;
   endtask

   task automatic run_op(input string tag, input muldiv_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cyc;
      issue(op, a, b);
      wait_done(cyc);
      check({tag, "_hilo"}, {hi_o, lo_o}, {exp_hi, exp_lo});
      step();
   endtask

   initial begin
      int cyc;
      logic seen;
      rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = OP_MULT; a_i = '0; b_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_done", {63'd0, done_o}, 64'd0);
      check("rst_dz", {63'd0, div_zero_o}, 64'd0);
      check("rst_hilo", {hi_o, lo_o}, 64'd0);
      rst_ni = 1'b1;
      step();

      // Reset in the middle of a divide
      issue(OP_MTLO, 32'h55, 32'h0);
      step();
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (5) step();
      #2 rst_ni = 1'b0;
      #1;
      check("midrst_busy", {63'd0, busy_o}, 64'd0);
      check("midrst_done", {63'd0, done_o}, 64'd0);
      check("midrst_hilo", {hi_o, lo_o}, 64'd0);
      step();
      rst_ni = 1'b1;
      run_op("mult3x5", OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15);

      // Latency and signed/unsigned multiply
      issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
      check("mult_busy", {63'd0, busy_o}, 64'd1);
      wait_done(cyc);
      check("mult_latency", 64'(cyc), 64'd34);
      check("mult_busy_at_done", {63'd0, busy_o}, 64'd0);
      check("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
      step();
      check("mult_done_pulse", {63'd0, done_o}, 64'd0);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);

      // Signed divide
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(cyc);
      check("div_min_hilo", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
      check("div_min_dz", {63'd0, div_zero_o}, 64'd0);
      step();

      // MTHI/MTLO then accumulate
      issue(OP_MTHI, 32'h1, 32'h0);
      check("mthi_val", {32'd0, hi_o}, 64'h1);
      check("mthi_done", {63'd0, done_o}, 64'd1);
      check("mthi_busy", {63'd0, busy_o}, 64'd0);
      step();
      run_op("mtlo", OP_MTLO, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFF);
      run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'h2, 32'h0);
      run_op("msub", OP_MSUB, 32'd1, 32'd2, 32'h1, 32'hFFFF_FFFE);

      // Divide by zero keeps HI/LO
      run_op("pre_hi", OP_MTHI, 32'hA, 32'h0, 32'hA, 32'hFFFF_FFFE);
      run_op("pre_lo", OP_MTLO, 32'hB, 32'h0, 32'hA, 32'hB);
      issue(OP_DIVU, 32'd5, 32'd0);
      check("dz_done", {63'd0, done_o}, 64'd1);
      check("dz_flag", {63'd0, div_zero_o}, 64'd1);
      check("dz_busy", {63'd0, busy_o}, 64'd1);
      check("dz_hilo", {hi_o, lo_o}, {32'hA, 32'hB});
      step();
      check("dz_flag_clr", {62'd0, div_zero_o, busy_o}, 64'd0);

      // Flush during a multiply
      issue(OP_MULT, 32'd7, 32'd9);
      repeat (8) step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("flush_busy", {63'd0, busy_o}, 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done_o) seen = 1'b1;
         step();
      end
      check("flush_nodone", {63'd0, seen}, 64'd0);
      check("flush_hilo", {hi_o, lo_o}, {32'hA, 32'hB});

      // Start and flush together: not accepted
      flush_i = 1'b1;
      issue(OP_MULT, 32'd7, 32'd9);
      flush_i = 1'b0;
      check("sf_busy", {63'd0, busy_o}, 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done_o) seen = 1'b1;
         step();
      end
      check("sf_nodone", {63'd0, seen}, 64'd0);
      check("sf_hilo", {hi_o, lo_o}, {32'hA, 32'hB});

      // Back-to-back: start during the done cycle
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_done(cyc);
      check("divu_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
      issue(OP_MULTU, 32'd6, 32'd7);
      check("b2b_accept", {63'd0, busy_o}, 64'd1);
      wait_done(cyc);
      check("b2b_latency", 64'(cyc), 64'd34);
      check("b2b_hilo", {hi_o, lo_o}, {32'd0, 32'd42});
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
